// File: rtl/four_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : four_stage_pipe
// Function : Register-read / ALU / write-back / memory-store pipeline, one
//            instruction per clock, no hazard forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module four_stage_pipe #(
    parameter int DW     = 16,
    parameter int NREG   = 16,
    parameter int MDEPTH = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(NREG)-1:0]   rd,
    input  logic [$clog2(NREG)-1:0]   rs1,
    input  logic [$clog2(NREG)-1:0]   rs2,
    input  logic [3:0]                func,
    input  logic [$clog2(MDEPTH)-1:0] addr,
    output logic [DW-1:0]             zout
);

    localparam int c_RW = $clog2(NREG);
    localparam int c_AW = $clog2(MDEPTH);

    // Storage is never reset; benches preload and inspect it hierarchically.
    logic [DW-1:0] regbank [0:NREG-1];
    logic [DW-1:0] memory  [0:MDEPTH-1];

    // S1/S2
    logic [DW-1:0]   r_a1;
    logic [DW-1:0]   r_b1;
    logic [c_RW-1:0] r_rd1;
    logic [3:0]      r_func1;
    logic [c_AW-1:0] r_addr1;
    logic            r_v1;
    // S2/S3
    logic [DW-1:0]   r_z2;
    logic [c_RW-1:0] r_rd2;
    logic [c_AW-1:0] r_addr2;
    logic            r_v2;
    // S3/S4
    logic [DW-1:0]   r_z3;
    logic [c_AW-1:0] r_addr3;
    logic            r_v3;

    logic [DW-1:0]   w_alu;

    always_comb begin
        w_alu = '0;
        case (r_func1)
            4'd0:    w_alu = r_a1 + r_b1;
            4'd1:    w_alu = r_a1 - r_b1;
            4'd2:    w_alu = r_a1 * r_b1;
            4'd3:    w_alu = r_a1;
            4'd4:    w_alu = r_b1;
            4'd5:    w_alu = r_a1 & r_b1;
            4'd6:    w_alu = r_a1 | r_b1;
            4'd7:    w_alu = r_a1 ^ r_b1;
            4'd8:    w_alu = ~r_a1;
            4'd9:    w_alu = ~r_b1;
            4'd10:   w_alu = r_a1 >> 1;
            4'd11:   w_alu = r_a1 << 1;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a1    <= '0;
            r_b1    <= '0;
            r_rd1   <= '0;
            r_func1 <= '0;
            r_addr1 <= '0;
            r_v1    <= 1'b0;
            r_z2    <= '0;
            r_rd2   <= '0;
            r_addr2 <= '0;
            r_v2    <= 1'b0;
            r_z3    <= '0;
            r_addr3 <= '0;
            r_v3    <= 1'b0;
        end else begin
            r_a1    <= regbank[rs1];
            r_b1    <= regbank[rs2];
            r_rd1   <= rd;
            r_func1 <= func;
            r_addr1 <= addr;
            r_v1    <= 1'b1;
            r_z2    <= w_alu;
            r_rd2   <= r_rd1;
            r_addr2 <= r_addr1;
            r_v2    <= r_v1;
            r_z3    <= r_z2;
            r_addr3 <= r_addr2;
            r_v3    <= r_v2;
        end
    end

    // Same-edge S1 read of a register being written here sees the old value.
    always_ff @(posedge clk) begin
        if (!rst && r_v2) begin
            regbank[r_rd2] <= r_z2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_v3) begin
            memory[r_addr3] <= r_z3;
        end
    end

    assign zout = r_z3;

endmodule
`default_nettype wire

// File: tb/tb_four_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_stage_pipe
// Function : Self-checking bench for four_stage_pipe against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_four_stage_pipe;

    logic        clk;
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] zout;

    int n_assert;
    int n_fail;

    four_stage_pipe #(.DW(16), .NREG(16), .MDEPTH(256)) dut (
        .clk  (clk),
        .rst  (rst),
        .rd   (rd),
        .rs1  (rs1),
        .rs2  (rs2),
        .func (func),
        .addr (addr),
        .zout (zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each issued instruction resolves its result at issue time (operands
    // read before that edge's write-back), lands in the register file two
    // edges later and in memory three edges later.
    typedef struct {
        int unsigned cyc;
        logic [15:0] res;
        logic [3:0]  rd;
        logic [7:0]  addr;
    } inflight_t;

    inflight_t   q[$];
    int unsigned cyc;
    logic [15:0] ref_reg [0:15];
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_z;

    function automatic logic [15:0] alu_ref(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned r;
        case (f)
            4'd0:    r = ua + ub;
            4'd1:    r = ua - ub;
            4'd2:    r = ua * ub;
            4'd3:    r = ua;
            4'd4:    r = ub;
            4'd5:    r = ua & ub;
            4'd6:    r = ua | ub;
            4'd7:    r = ua ^ ub;
            4'd8:    r = ~ua;
            4'd9:    r = ~ub;
            4'd10:   r = ua / 2;
            4'd11:   r = ua * 2;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        inflight_t n;
        exp_z = 16'h0;
        if (rst) begin
            q.delete();
        end else begin
            n.cyc  = cyc;
            n.res  = alu_ref(ref_reg[rs1], ref_reg[rs2], func);
            n.rd   = rd;
            n.addr = addr;
            foreach (q[i]) begin
                if (q[i].cyc + 2 == cyc) begin
                    ref_reg[q[i].rd] = q[i].res;
                    exp_z = q[i].res;
                end
                if (q[i].cyc + 3 == cyc) ref_mem[q[i].addr] = q[i].res;
            end
            while (q.size() > 0 && q[0].cyc + 3 <= cyc) void'(q.pop_front());
            q.push_back(n);
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tick();
        chk("zout", zout, exp_z);
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f,
                         input logic [3:0] d, input logic [7:0] m);
        rs1 = a; rs2 = b; func = f; rd = d; addr = m;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        #1;
        q.delete();
        chk("zout_in_reset", zout, 16'h0);
    endtask

    task automatic check_all();
        for (int k = 0; k < 16; k++)  chk($sformatf("regbank[%0d]", k), dut.regbank[k], ref_reg[k]);
        for (int k = 0; k < 256; k++) chk($sformatf("memory[%0d]", k), dut.memory[k], ref_mem[k]);
    endtask

    task automatic reset_preload();
        assert_rst();
        for (int k = 0; k < 16; k++) begin
            dut.regbank[k] = 16'(k);
            ref_reg[k]     = 16'(k);
        end
        step();
        rst = 1'b0;
    endtask

    logic [3:0]  fn_tab  [0:6];
    logic [15:0] exp_tab [0:6];
    logic [3:0]  sq_fn   [0:3];
    logic [15:0] sq_exp  [0:3];
    logic [15:0] w;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
        for (int k = 0; k < 16; k++) begin
            w = 16'($urandom);
            dut.regbank[k] = w;
            ref_reg[k]     = w;
        end
        for (int k = 0; k < 256; k++) begin
            w = 16'($urandom);
            dut.memory[k] = w;
            ref_mem[k]    = w;
        end

        // Power-up under reset: random instructions must not write anything.
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
            step();
        end
        check_all();

        // Held add: r10 <= r3 + r5, stored to memory[125].
        reset_preload();
        drive(4'd3, 4'd5, 4'd0, 4'd10, 8'd125);
        step();
        step();
        step();
        chk("add_zout", zout, 16'd8);
        chk("add_reg10", dut.regbank[10], 16'd8);
        step();
        chk("add_mem125", dut.memory[125], 16'd8);
        for (int k = 126; k < 130; k++) chk($sformatf("add_mem%0d_untouched", k), dut.memory[k], ref_mem[k]);

        fn_tab  = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd10, 4'd11, 4'd13};
        exp_tab = '{16'hFFFE, 16'd15, 16'd6, 16'hFFFC, 16'd1, 16'd6, 16'd0};
        for (int i = 0; i < 7; i++) begin
            reset_preload();
            drive(4'd3, 4'd5, fn_tab[i], 4'd10, 8'd125);
            step();
            step();
            step();
            chk($sformatf("alu_func%0d", fn_tab[i]), zout, exp_tab[i]);
        end

        // Read-after-write without forwarding.
        reset_preload();
        drive(4'd3, 4'd5, 4'd0, 4'd10, 8'd10);
        step();
        drive(4'd10, 4'd1, 4'd0, 4'd11, 8'd11);
        step();
        step();
        step();
        chk("raw_stale_r11", dut.regbank[11], 16'd11);
        step();
        step();
        chk("raw_fresh_r11", dut.regbank[11], 16'd9);

        // One store per cycle to consecutive addresses.
        reset_preload();
        sq_fn  = '{4'd0, 4'd1, 4'd5, 4'd6};
        sq_exp = '{16'd8, 16'hFFFE, 16'd1, 16'd7};
        for (int i = 0; i < 4; i++) begin
            drive(4'd3, 4'd5, sq_fn[i], 4'(12 + i), 8'(125 + i));
            step();
        end
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) chk($sformatf("seq_mem%0d", 125 + i), dut.memory[125 + i], sq_exp[i]);
        check_all();

        // Reset squashes an in-flight store.
        reset_preload();
        dut.memory[200] = 16'h1234;
        ref_mem[200]    = 16'h1234;
        drive(4'd3, 4'd5, 4'd0, 4'd10, 8'd200);
        step();
        drive(4'd2, 4'd0, 4'd3, 4'd2, 8'd60);
        step();
        assert_rst();
        step();
        step();
        chk("rst_mem200", dut.memory[200], 16'h1234);
        chk("rst_reg10", dut.regbank[10], 16'd10);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_all();

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), 4'($urandom), 8'($urandom));
            if ($urandom_range(0, 59) == 0) begin
                assert_rst();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        for (int i = 0; i < 4; i++) step();
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
